// File: rtl/pc_fetch_pkg.sv
// -----------------------------------------------------------------------------
// pc_fetch_pkg
// Shared core definitions for the fetch front end:
//   - fetch_state_t     : fetch sequencer FSM states
//   - RESET_PC_DEFAULT  : default PC loaded on reset
//   - NOP_INST          : canonical NOP (addi x0,x0,0), also used by decode
//   - is_aligned()      : word-alignment test for instruction addresses
// -----------------------------------------------------------------------------
package pc_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_VALID = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_t;

    // RV32 without the C extension: every fetch address must be word aligned.
    function automatic logic is_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage : pc_fetch_pkg

// File: rtl/pc_fetch.sv
// -----------------------------------------------------------------------------
// pc_fetch
// Program-counter register and instruction-fetch sequencer for the single-issue
// RV32 core. Fetches the word at pc over a req/gnt/rvalid port, presents it to
// decode, and loads npc from the NPC stage when the current instruction retires.
//
// Ports:
//   clk, rst        core clock, asynchronous active-high reset
//   npc, pc_update  next PC from NPC stage; load it when the instruction retires
//   imem_req/addr   fetch request (held until granted) and its address (== pc)
//   imem_gnt        request accepted this cycle
//   imem_rvalid     response valid; imem_rdata / imem_err qualified by it
//   pc              current architectural PC
//   inst/inst_valid fetched instruction (NOP_INST unless inst_valid)
//   fetch_fault     sticky: misaligned npc or bus error; cleared only by rst
//   instret         retired-instruction count, wraps at 2^32
//
// Every output is decoded from registered state; no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module pc_fetch #(
    parameter logic [31:0] RESET_PC = pc_fetch_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = pc_fetch_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc,
    input  logic        pc_update,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        fetch_fault,
    output logic [31:0] instret
);
    import pc_fetch_pkg::*;

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  instret_q, instret_d;

    // Next-state logic. Responses are only honoured in WAIT and retirements
    // only in VALID; anything else the bus or core does is ignored.
    always_comb begin
        // NOTE: every signal gets a hold default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        instret_d = instret_q;

        case (state_q)
            ST_IDLE: state_d = ST_REQ;

            ST_REQ: begin
                if (imem_gnt) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (imem_rvalid) begin
                    if (imem_err) begin
                        state_d = ST_FAULT;
                    end else begin
                        inst_d  = imem_rdata;
                        state_d = ST_VALID;
                    end
                end
            end

            ST_VALID: begin
                if (pc_update) begin
                    if (is_aligned(npc)) begin
                        pc_d      = npc;
                        instret_d = instret_q + 32'd1;
                        state_d   = ST_REQ;
                    end else begin
                        // Misaligned target: keep pc/instret so the faulting
                        // instruction's PC stays visible for debug.
                        state_d = ST_FAULT;
                    end
                end
            end

            ST_FAULT: state_d = ST_FAULT;

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: inst_q is reset even though the output masks it outside
            // VALID, so no X ever propagates from an unloaded register.
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            inst_q    <= NOP_INST;
            instret_q <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values of the others.
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            instret_q <= instret_d;
        end
    end

    assign imem_req    = (state_q == ST_REQ);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign inst_valid  = (state_q == ST_VALID);
    assign inst        = inst_valid ? inst_q : NOP_INST;
    assign fetch_fault = (state_q == ST_FAULT);
    assign instret     = instret_q;

endmodule : pc_fetch

// File: tb/tb_pc_fetch.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch
// Self-checking bench for pc_fetch. The bench plays the instruction memory,
// drives inputs 1 time unit after each rising edge and samples outputs there.
// Directed sequences cover reset, latency, delayed handshakes, faults, counter
// wrap and reset mid-fetch; a vector table covers a run of fetch/retire pairs;
// a random phase checks against a transaction-level model (pc, count, fault).
// -----------------------------------------------------------------------------
module tb_pc_fetch;

    localparam logic [31:0] EXP_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] EXP_NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] npc = 32'd0;
    logic        pc_update = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_err = 1'b0;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic        fetch_fault;
    logic [31:0] instret;

    int n_checks = 0;
    int n_errors = 0;
    int cycle    = 0;

    pc_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .npc         (npc),
        .pc_update   (pc_update),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .imem_err    (imem_err),
        .pc          (pc),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .fetch_fault (fetch_fault),
        .instret     (instret)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          gnt_dly;
        int          rv_dly;
        int          hold;
        logic [31:0] rdata;
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] exp_instret;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic clear_inputs();
        pc_update   = 1'b0;
        npc         = 32'd0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_err    = 1'b0;
        imem_rdata  = 32'd0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req"},     imem_req,    1'b0);
        check({tag, "_valid"},   inst_valid,  1'b0);
        check({tag, "_fault"},   fetch_fault, 1'b0);
        check({tag, "_inst"},    inst,        EXP_NOP);
        check({tag, "_pc"},      pc,          EXP_RESET_PC);
        check({tag, "_addr"},    imem_addr,   EXP_RESET_PC);
        check({tag, "_instret"}, instret,     32'd0);
    endtask

    // One-cycle reset; returns with rst just released, DUT in IDLE.
    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        check_reset_values("reset");
        rst = 1'b0;
    endtask

    // Plays one fetch from the memory side. Optional noise injects traffic
    // that must be ignored: responses while in REQ, retirements while waiting.
    task automatic fetch(input int gnt_dly, input int rv_dly, input logic err,
                         input logic [31:0] data, input logic [31:0] exp_pc,
                         input logic noise);
        int waited = 0;
        while (imem_req !== 1'b1 && waited < 8) begin
            tick();
            waited++;
        end
        check("req_rise", imem_req, 1'b1);
        check("req_addr", imem_addr, exp_pc);
        for (int i = 0; i < gnt_dly; i++) begin
            if (noise) begin
                imem_rvalid = 1'b1;
                imem_err    = 1'b1;
                imem_rdata  = 32'hBADB_AD00;
                pc_update   = 1'b1;
                npc         = 32'h0000_0003;
            end
            tick();
            check("req_held", imem_req, 1'b1);
            check("addr_stable", imem_addr, exp_pc);
        end
        clear_inputs();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        check("req_drop", imem_req, 1'b0);
        for (int i = 0; i < rv_dly; i++) begin
            if (noise) begin
                pc_update = 1'b1;
                npc       = 32'h0000_0003;
            end
            tick();
            check("wait_req", imem_req, 1'b0);
            check("wait_fault", fetch_fault, 1'b0);
        end
        pc_update = 1'b0;
        check("wait_valid", inst_valid, 1'b0);
        check("wait_pc", pc, exp_pc);
        imem_rvalid = 1'b1;
        imem_err    = err;
        imem_rdata  = data;
        tick();
        clear_inputs();
        if (err) begin
            check("err_fault", fetch_fault, 1'b1);
            check("err_valid", inst_valid, 1'b0);
            check("err_inst", inst, EXP_NOP);
            check("err_req", imem_req, 1'b0);
        end else begin
            check("rsp_valid", inst_valid, 1'b1);
            check("rsp_inst", inst, data);
            check("rsp_pc", pc, exp_pc);
            check("rsp_fault", fetch_fault, 1'b0);
        end
    endtask

    // Stay in VALID with stray bus traffic that must not disturb anything.
    task automatic hold_valid(input int n, input logic [31:0] exp_inst);
        for (int i = 0; i < n; i++) begin
            imem_rvalid = 1'b1;
            imem_err    = 1'b1;
            imem_rdata  = ~exp_inst;
            imem_gnt    = 1'b1;
            tick();
            check("hold_valid", inst_valid, 1'b1);
            check("hold_inst", inst, exp_inst);
            check("hold_fault", fetch_fault, 1'b0);
        end
        clear_inputs();
    endtask

    task automatic retire(input logic [31:0] next_pc, input logic [31:0] exp_count);
        pc_update = 1'b1;
        npc       = next_pc;
        tick();
        clear_inputs();
        check("ret_pc", pc, next_pc);
        check("ret_addr", imem_addr, next_pc);
        check("ret_instret", instret, exp_count);
        check("ret_valid", inst_valid, 1'b0);
        check("ret_inst", inst, EXP_NOP);
        check("ret_req", imem_req, 1'b1);
    endtask

    // Fault must be sticky with no requests, whatever the bus does.
    task automatic check_fault_sticky(input logic [31:0] exp_pc, input logic [31:0] exp_count);
        for (int i = 0; i < 3; i++) begin
            imem_gnt    = 1'b1;
            imem_rvalid = 1'b1;
            pc_update   = 1'b1;
            npc         = 32'h0000_0100;
            tick();
            check("fault_sticky", fetch_fault, 1'b1);
            check("fault_no_req", imem_req, 1'b0);
            check("fault_valid", inst_valid, 1'b0);
            check("fault_pc", pc, exp_pc);
            check("fault_instret", instret, exp_count);
        end
        clear_inputs();
    endtask

    initial begin
        logic [31:0] m_pc;
        logic [31:0] m_instret;
        int          c0;

        vecs[0] = '{gnt_dly: 3, rv_dly: 2, hold: 0, rdata: 32'h1111_1111,
                    pc: 32'h0000_0040, npc: 32'h0000_0044, exp_instret: 32'd2};
        vecs[1] = '{gnt_dly: 0, rv_dly: 0, hold: 2, rdata: 32'h2222_2222,
                    pc: 32'h0000_0044, npc: 32'h0000_0044, exp_instret: 32'd3};
        vecs[2] = '{gnt_dly: 1, rv_dly: 3, hold: 1, rdata: 32'h3333_3333,
                    pc: 32'h0000_0044, npc: 32'h0000_1000, exp_instret: 32'd4};
        vecs[3] = '{gnt_dly: 2, rv_dly: 0, hold: 0, rdata: 32'h4444_4444,
                    pc: 32'h0000_1000, npc: 32'hFFFF_FFFC, exp_instret: 32'd5};
        vecs[4] = '{gnt_dly: 0, rv_dly: 1, hold: 3, rdata: 32'h5555_5555,
                    pc: 32'hFFFF_FFFC, npc: 32'h0000_0000, exp_instret: 32'd6};

        // Reset release and zero-wait first fetch.
        do_reset();
        c0 = cycle;
        tick();
        check("first_req_cycle1", imem_req, 1'b1);
        fetch(0, 0, 1'b0, 32'h0050_0093, 32'h0000_0000, 1'b0);
        check("first_valid_at_cycle3", cycle - c0, 3);

        // First retirement.
        retire(32'h0000_0040, 32'd1);

        // Vector table: delayed handshakes, self-loop, wrap of address space.
        for (int i = 0; i < 5; i++) begin
            fetch(vecs[i].gnt_dly, vecs[i].rv_dly, 1'b0, vecs[i].rdata, vecs[i].pc, 1'b1);
            hold_valid(vecs[i].hold, vecs[i].rdata);
            retire(vecs[i].npc, vecs[i].exp_instret);
        end

        // Misaligned npc: sticky fault, pc and count frozen.
        fetch(0, 0, 1'b0, 32'h0000_0013, 32'h0000_0000, 1'b0);
        pc_update = 1'b1;
        npc       = 32'h0000_0042;
        tick();
        clear_inputs();
        check("misalign_fault", fetch_fault, 1'b1);
        check("misalign_pc", pc, 32'h0000_0000);
        check("misalign_instret", instret, 32'd6);
        check_fault_sticky(32'h0000_0000, 32'd6);

        // Bus error in WAIT, then one-cycle reset restores everything.
        do_reset();
        fetch(1, 1, 1'b1, 32'hCAFE_0000, 32'h0000_0000, 1'b0);
        check_fault_sticky(32'h0000_0000, 32'd0);
        do_reset();

        // Counter wrap via preload.
        fetch(0, 0, 1'b0, 32'h0010_0113, 32'h0000_0000, 1'b0);
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        retire(32'h0000_0008, 32'd0);

        // Async reset while in WAIT; a later response must not be latched.
        check("prewait_req", imem_req, 1'b1);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        rst = 1'b0;
        imem_rvalid = 1'b0;
        check("rst_no_latch_valid", inst_valid, 1'b0);
        check("rst_no_latch_inst", inst, EXP_NOP);
        tick();
        check("rst_restart_req", imem_req, 1'b1);
        check("rst_restart_addr", imem_addr, EXP_RESET_PC);

        // Random phase against a transaction-level model.
        m_pc      = EXP_RESET_PC;
        m_instret = 32'd0;
        for (int t = 0; t < 40; t++) begin
            logic [31:0] data;
            logic [31:0] target;
            logic        err;
            data   = $urandom;
            err    = ($urandom_range(0, 15) == 0);
            fetch(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), err,
                  data, m_pc, 1'($urandom_range(0, 1)));
            if (err) begin
                check("rnd_err_pc", pc, m_pc);
                check("rnd_err_instret", instret, m_instret);
                do_reset();
                m_pc      = EXP_RESET_PC;
                m_instret = 32'd0;
                continue;
            end
            hold_valid(int'($urandom_range(0, 2)), data);
            target = $urandom;
            if ($urandom_range(0, 7) != 0) begin
                target[1:0] = 2'b00;
            end else if (target[1:0] == 2'b00) begin
                target[1:0] = 2'b10;
            end
            if (target[1:0] == 2'b00) begin
                m_pc      = target;
                m_instret = m_instret + 32'd1;
                retire(target, m_instret);
            end else begin
                pc_update = 1'b1;
                npc       = target;
                tick();
                clear_inputs();
                check("rnd_misalign_fault", fetch_fault, 1'b1);
                check("rnd_misalign_pc", pc, m_pc);
                check("rnd_misalign_instret", instret, m_instret);
                do_reset();
                m_pc      = EXP_RESET_PC;
                m_instret = 32'd0;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_pc_fetch
